// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous RAM port between instruction fetch and data access.
module mem_port_arbiter #(
  parameter int ADDR_W = 14,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output logic              stall
);
  localparam int CW = $clog2(STARVE_LIMIT + 2);
  typedef enum logic [1:0] {IDLE, RSP_IF, RSP_D} state_t;
  state_t state, state_nx;
  logic [CW-1:0] starve_cnt;
  logic fetch_pri;
  // Data normally wins; a fetch starved for STARVE_LIMIT cycles overrides it.
  always_comb begin
    fetch_pri = starve_cnt == CW'(STARVE_LIMIT);
    if_gnt = !rst && if_req && (!d_req || fetch_pri);
    d_gnt = !rst && d_req && !if_gnt;
    stall = !rst && ((if_req && !if_gnt) || (d_req && !d_gnt));
    mem_en = if_gnt || d_gnt;
    mem_we = d_gnt ? d_we : 4'b0;
    mem_addr = if_gnt ? if_addr : d_gnt ? d_addr : '0;
    mem_din = d_gnt ? d_wdata : 32'b0;
    state_nx = if_gnt ? RSP_IF : (d_gnt && d_we == 4'b0) ? RSP_D : IDLE;
    if_rvalid = !rst && state == RSP_IF;
    d_rvalid = !rst && state == RSP_D;
    if_rdata = if_rvalid ? mem_dout : 32'b0;
    d_rdata = d_rvalid ? mem_dout : 32'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      starve_cnt <= '0;
    end else begin
      state <= state_nx;
      starve_cnt <= (if_req && !if_gnt) ? (fetch_pri ? starve_cnt : starve_cnt + CW'(1)) : '0;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scenarios against a word-level memory and priority model.
module tb_mem_port_arbiter;
  localparam int A = 14;
  localparam int L = 3;
  logic clk = 0;
  logic rst = 1, if_req = 0, d_req = 0;
  logic [A-1:0] if_addr = '0, d_addr = '0;
  logic [3:0] d_we = '0;
  logic [31:0] d_wdata = '0;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, stall;
  logic [31:0] if_rdata, d_rdata, mem_din, mem_dout;
  logic [3:0] mem_we;
  logic [A-1:0] mem_addr;
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(A), .STARVE_LIMIT(L)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .stall(stall)
  );

  logic [31:0] ram [0:(1<<A)-1];
  logic [31:0] mdl [0:(1<<A)-1];
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we == 4'b0) mem_dout <= ram[mem_addr];
      else for (int b = 0; b < 4; b++) if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
    end

  wire [119:0] o = {if_gnt, d_gnt, stall, mem_en, mem_we, mem_addr, mem_din,
                    if_rvalid, if_rdata, d_rvalid, d_rdata};
  logic [119:0] e;
  int m_cnt = 0, m_pend = 0;
  logic [31:0] m_data = '0;
  logic g_if = 0, g_d = 0;
  int n_vec = 0, n_err = 0;

  task automatic apply(input logic r, input logic ireq, input logic [A-1:0] ia, input logic dreq,
                       input logic [3:0] dwe, input logic [A-1:0] da, input logic [31:0] dwd);
    logic ei, ed, st, iv, dv;
    logic [A-1:0] ma;
    @(negedge clk);
    rst = r; if_req = ireq; if_addr = ia; d_req = dreq; d_we = dwe; d_addr = da; d_wdata = dwd;
    #1;
    ei = !r && ireq && (!dreq || m_cnt == L);
    ed = !r && dreq && !ei;
    st = !r && ((ireq && !ei) || (dreq && !ed));
    ma = ei ? ia : ed ? da : '0;
    iv = !r && m_pend == 1;
    dv = !r && m_pend == 2;
    e = {ei, ed, st, ei || ed, ed ? dwe : 4'b0, ma, ed ? dwd : 32'b0,
         iv, iv ? m_data : 32'b0, dv, dv ? m_data : 32'b0};
    g_if = ei; g_d = ed;
    if (r) begin
      m_cnt = 0; m_pend = 0;
    end else begin
      m_cnt = (ireq && !ei) ? (m_cnt < L ? m_cnt + 1 : L) : 0;
      m_pend = ei ? 1 : (ed && dwe == 4'b0) ? 2 : 0;
      if (ei) m_data = mdl[ia];
      else if (ed && dwe == 4'b0) m_data = mdl[da];
      if (ed) for (int b = 0; b < 4; b++) if (dwe[b]) mdl[da][8*b +: 8] = dwd[8*b +: 8];
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 5; i++) begin
      apply(1, 1'($urandom), A'($urandom), 1'($urandom), 4'($urandom), A'($urandom), $urandom);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL reset c%0d got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_idle;
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, A'($urandom), 0, 4'($urandom), A'($urandom), $urandom);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL idle c%0d got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_fetch_only;
    for (int i = 0; i < 4; i++) begin
      apply(0, i < 3, A'(16), 0, 4'b0, '0, 32'b0);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL fetch_only c%0d got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_starve;
    for (int i = 0; i < 13; i++) begin
      apply(0, i < 12, A'(5), i < 12, 4'b0, A'(6), 32'b0);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL starve c%0d got %h want %h", i, o, e); end
      if (i < 12) begin
        n_vec++;
        if (if_gnt !== (i % 4 == 3)) begin n_err++; $display("FAIL starve_pattern c%0d got %b want %b", i, if_gnt, i % 4 == 3); end
      end
    end
  endtask

  task automatic test_store_load;
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, '0, i < 2, i == 0 ? 4'hF : 4'h0, A'(32), 32'hDEADBEEF);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL store_load c%0d got %h want %h", i, o, e); end
    end
    n_vec++;
    if (d_rdata !== 32'hDEADBEEF || !d_rvalid) begin n_err++; $display("FAIL store_load_data got %h want deadbeef", d_rdata); end
  endtask

  task automatic test_partial;
    logic [3:0] we_t [3] = '{4'hF, 4'b0010, 4'h0};
    logic [31:0] wd_t [3] = '{32'h11223344, 32'h0000AB00, 32'h0};
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, '0, i < 3, i < 3 ? we_t[i] : 4'h0, A'(48), i < 3 ? wd_t[i] : 32'h0);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL partial c%0d got %h want %h", i, o, e); end
    end
    n_vec++;
    if (d_rdata !== 32'h1122AB44 || !d_rvalid) begin n_err++; $display("FAIL partial_data got %h want 1122ab44", d_rdata); end
  endtask

  task automatic test_reset_mid;
    logic [6:0] r_t = 7'b0001010;
    logic [6:0] ld_t = 7'b0000101;
    for (int i = 0; i < 7; i++) begin
      apply(r_t[i], 0, '0, ld_t[i], 4'h0, A'(32), 32'h0);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL reset_mid c%0d got %h want %h", i, o, e); end
    end
    for (int i = 0; i < 8; i++) begin
      apply(i == 2, 1, A'(7), i != 2 && i != 1 ? 1'b1 : 1'b0, 4'h0, A'(8), 32'h0);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL starve_reset c%0d got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_random;
    logic ir = 0, dr = 0;
    logic [A-1:0] ia = '0, da = '0;
    logic [3:0] dw = '0;
    logic [31:0] dd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!ir || g_if) begin ir = 1'($urandom_range(0, 3) != 0); ia = A'($urandom_range(0, 15)); end
      if (!dr || g_d) begin
        dr = 1'($urandom_range(0, 2) != 0); da = A'($urandom_range(0, 15));
        dw = $urandom_range(0, 1) ? 4'($urandom) : 4'h0; dd = $urandom;
      end
      apply($urandom_range(0, 39) == 0, ir, ia, dr, dw, da, dd);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL random c%0d got %h want %h", i, o, e); end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << A); i++) begin
      ram[i] = i * 32'h9E3779B9 ^ 32'h5A5A0F0F;
      mdl[i] = ram[i];
    end
    test_reset;
    test_idle;
    test_fetch_only;
    test_starve;
    test_store_load;
    test_partial;
    test_reset_mid;
    test_random;
    test_idle;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
